// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam slot_idx_t SLOT_A = 2'd0;
    localparam slot_idx_t SLOT_B = 2'd1;
    localparam slot_idx_t SLOT_C = 2'd2;
    localparam slot_idx_t SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-4 slot position counter; clear wins over load-to-1, which wins over increment.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_load1,
    input  logic       i_inc,
    output logic [1:0] o_slot
);

    slot_idx_t r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= SLOT_A;
        end else if (i_clear) begin
            r_slot <= SLOT_A;
        end else if (i_load1) begin
            r_slot <= SLOT_B;
        end else if (i_inc) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/tdm_demux_1to4.sv
// Recovers four channels from a TDM beat stream aligned by a start-of-frame strobe,
// publishing one parallel word per channel each complete frame.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit SOF_STRICT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] y_a,
    output logic [WIDTH-1:0] y_b,
    output logic [WIDTH-1:0] y_c,
    output logic [WIDTH-1:0] y_d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [1:0]       slot
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shadow [0:NUM_SLOTS-2];
    logic [WIDTH-1:0] r_yA, r_yB, r_yC, r_yD;
    logic             r_frameValid;
    logic             r_syncErr;

    slot_idx_t w_slot;
    logic      w_enter;
    logic      w_early;
    logic      w_strictErr;
    logic      w_accept;
    logic      w_frameDone;

    // Early sof takes priority over normal acceptance; slot-0 beats without sof only fault in strict mode.
    always_comb begin
        w_enter     = din_valid && sof && (r_state == HUNT);
        w_early     = din_valid && sof && (r_state == LOCKED) && (w_slot != SLOT_A);
        w_strictErr = SOF_STRICT && din_valid && !sof && (r_state == LOCKED) && (w_slot == SLOT_A);
        w_accept    = din_valid && (r_state == LOCKED) && !w_early && !w_strictErr;
        w_frameDone = w_accept && (w_slot == SLOT_D);
    end

    tdm_slot_counter u_slotCounter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_strictErr),
        .i_load1 (w_enter || w_early),
        .i_inc   (w_accept),
        .o_slot  (w_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else if (w_enter) begin
            r_state <= LOCKED;
        end else if (w_strictErr) begin
            r_state <= HUNT;
        end
    end

    // The slot-3 beat bypasses the shadow and goes straight to y_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if ((i == 0) && (w_enter || w_early)) begin
                    r_shadow[i] <= din;
                end else if (w_accept && (w_slot == slot_idx_t'(i))) begin
                    r_shadow[i] <= din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yA         <= '0;
            r_yB         <= '0;
            r_yC         <= '0;
            r_yD         <= '0;
            r_frameValid <= 1'b0;
            r_syncErr    <= 1'b0;
        end else begin
            r_frameValid <= w_frameDone;
            r_syncErr    <= w_early || w_strictErr;
            if (w_frameDone) begin
                r_yA <= r_shadow[0];
                r_yB <= r_shadow[1];
                r_yC <= r_shadow[2];
                r_yD <= din;
            end
        end
    end

    assign y_a         = r_yA;
    assign y_b         = r_yB;
    assign y_c         = r_yC;
    assign y_d         = r_yD;
    assign frame_valid = r_frameValid;
    assign sync_err    = r_syncErr;
    assign locked      = (r_state == LOCKED);
    assign slot        = w_slot;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench: a strict and a flywheel instance share one 4-bit stimulus stream.
module tb_tdm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;

    logic [3:0] sYa, sYb, sYc, sYd;
    logic       sFv, sLk, sSe;
    logic [1:0] sSlot;
    logic [3:0] fYa, fYb, fYc, fYd;
    logic       fFv, fLk, fSe;
    logic [1:0] fSlot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_demux_1to4 #(.WIDTH(4), .SOF_STRICT(1'b1)) dutS (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
        .y_a(sYa), .y_b(sYb), .y_c(sYc), .y_d(sYd),
        .frame_valid(sFv), .locked(sLk), .sync_err(sSe), .slot(sSlot)
    );

    tdm_demux_1to4 #(.WIDTH(4), .SOF_STRICT(1'b0)) dutF (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
        .y_a(fYa), .y_b(fYb), .y_c(fYc), .y_d(fYd),
        .frame_valid(fFv), .locked(fLk), .sync_err(fSe), .slot(fSlot)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one beat (or idle) at the falling edge; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [3:0] d);
        @(negedge clk);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkStrictOutputs(input string tag, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
        checkOutput({tag, ".y_a"}, 32'(sYa), 32'(a));
        checkOutput({tag, ".y_b"}, 32'(sYb), 32'(b));
        checkOutput({tag, ".y_c"}, 32'(sYc), 32'(c));
        checkOutput({tag, ".y_d"}, 32'(sYd), 32'(d));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        sof = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();
        #1;
        checkStrictOutputs("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("reset.locked", 32'(sLk), 32'd0);
        checkOutput("reset.slot", 32'(sSlot), 32'd0);
        checkOutput("reset.fv", 32'(sFv), 32'd0);

        applyStimulus(1'b1, 1'b1, 4'h1);
        checkOutput("t1.lockedAfterEntry", 32'(sLk), 32'd1);
        checkOutput("t1.slotAfterEntry", 32'(sSlot), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h2);
        applyStimulus(1'b1, 1'b0, 4'h3);
        checkOutput("t1.noEarlyFrame", 32'(sFv), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h4);
        checkStrictOutputs("t1", 4'h1, 4'h2, 4'h3, 4'h4);
        checkOutput("t1.fv", 32'(sFv), 32'd1);
        checkOutput("t1.slotWrap", 32'(sSlot), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("t1.fvPulse", 32'(sFv), 32'd0);
        checkStrictOutputs("t1.hold", 4'h1, 4'h2, 4'h3, 4'h4);

        doReset();
        applyStimulus(1'b1, 1'b0, 4'h5);
        checkOutput("t2.huntDrop.locked", 32'(sLk), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'hF);
        checkOutput("t2.sofNoValid.locked", 32'(sLk), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h6);
        checkOutput("t2.huntDrop.slot", 32'(sSlot), 32'd0);
        checkOutput("t2.huntDrop.serr", 32'(sSe), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'h7);
        checkOutput("t2.b0.serr", 32'(sSe), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h8);
        checkOutput("t2.b1.serr", 32'(sSe), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h9);
        applyStimulus(1'b1, 1'b0, 4'hA);
        checkOutput("t2.b3.serr", 32'(sSe), 32'd0);
        checkOutput("t2.fv", 32'(sFv), 32'd1);
        checkStrictOutputs("t2", 4'h7, 4'h8, 4'h9, 4'hA);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i == 0), 4'(4'hB + i));
            if (i < 3) begin
                checkOutput("t3.fvMidFrame", 32'(sFv), 32'd0);
                repeat (2) begin
                    applyStimulus(1'b0, 1'b0, 4'h0);
                    checkOutput("t3.slotHold", 32'(sSlot), 32'(i + 1));
                    checkOutput("t3.fvGap", 32'(sFv), 32'd0);
                end
            end
        end
        checkOutput("t3.fv", 32'(sFv), 32'd1);
        checkStrictOutputs("t3", 4'hB, 4'hC, 4'hD, 4'hE);

        applyStimulus(1'b1, 1'b1, 4'h1);
        applyStimulus(1'b1, 1'b0, 4'h2);
        applyStimulus(1'b1, 1'b1, 4'h5);
        checkOutput("t4.serr", 32'(sSe), 32'd1);
        checkOutput("t4.slot", 32'(sSlot), 32'd1);
        checkOutput("t4.locked", 32'(sLk), 32'd1);
        checkOutput("t4.noFrame", 32'(sFv), 32'd0);
        checkStrictOutputs("t4.keep", 4'hB, 4'hC, 4'hD, 4'hE);
        applyStimulus(1'b1, 1'b0, 4'h6);
        checkOutput("t4.serrPulse", 32'(sSe), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h7);
        applyStimulus(1'b1, 1'b0, 4'h8);
        checkOutput("t4.fv", 32'(sFv), 32'd1);
        checkStrictOutputs("t4", 4'h5, 4'h6, 4'h7, 4'h8);
        checkOutput("t4.flywheel.y_a", 32'(fYa), 32'h5);

        applyStimulus(1'b1, 1'b0, 4'h9);
        checkOutput("t5.strict.serr", 32'(sSe), 32'd1);
        checkOutput("t5.strict.locked", 32'(sLk), 32'd0);
        checkOutput("t5.strict.slot", 32'(sSlot), 32'd0);
        checkOutput("t5.fly.serr", 32'(fSe), 32'd0);
        checkOutput("t5.fly.locked", 32'(fLk), 32'd1);
        checkOutput("t5.fly.slot", 32'(fSlot), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'hA);
        applyStimulus(1'b1, 1'b0, 4'hB);
        applyStimulus(1'b1, 1'b0, 4'hC);
        checkOutput("t5.strict.fv", 32'(sFv), 32'd0);
        checkStrictOutputs("t5.strict.keep", 4'h5, 4'h6, 4'h7, 4'h8);
        checkOutput("t5.fly.fv", 32'(fFv), 32'd1);
        checkOutput("t5.fly.y_a", 32'(fYa), 32'h9);
        checkOutput("t5.fly.y_d", 32'(fYd), 32'hC);

        applyStimulus(1'b1, 1'b1, 4'h1);
        applyStimulus(1'b1, 1'b0, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkStrictOutputs("t6.async", 4'h0, 4'h0, 4'h0, 4'h0);
        checkOutput("t6.async.locked", 32'(sLk), 32'd0);
        checkOutput("t6.async.slot", 32'(sSlot), 32'd0);
        checkOutput("t6.async.fly.y_d", 32'(fYd), 32'h0);
        checkOutput("t6.async.fly.locked", 32'(fLk), 32'd0);
        din_valid = 1'b0;
        sof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h3);
        applyStimulus(1'b1, 1'b0, 4'h4);
        checkOutput("t6.partialLost.fv", 32'(sFv), 32'd0);
        checkOutput("t6.partialLost.fly.fv", 32'(fFv), 32'd0);
        applyStimulus(1'b1, 1'b1, 4'h1);
        applyStimulus(1'b1, 1'b0, 4'h2);
        applyStimulus(1'b1, 1'b0, 4'h3);
        checkOutput("t6.fvBeforeFull", 32'(sFv), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'h4);
        checkOutput("t6.fv", 32'(sFv), 32'd1);
        checkStrictOutputs("t6", 4'h1, 4'h2, 4'h3, 4'h4);
        applyStimulus(1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
